// File: rtl/config_pkg.sv
// config_pkg: shared core configuration and LSU operation encoding
package config_pkg;
    typedef struct packed {
        int unsigned XLEN;
        int unsigned PLEN;
    } cfg_t;
    localparam cfg_t EmptyCfg = '{XLEN: 64, PLEN: 56};
    typedef enum logic [1:0] {LSU_SB, LSU_SH, LSU_SW, LSU_SD} lsu_op_e;
endpackage

// File: rtl/store_buffer.sv
// store_buffer: circular store queue; alloc at dispatch, fill from LSU, forward to loads, commit in order, drain to D-cache
// ports: alloc_* dispatch handshake, sb_ex_* execute fill, sb_load_* forwarding query, commit_valid_i ROB retire,
//        st_req_* D-cache store port, flush_i drops uncommitted entries, sb_empty_o for fences
module store_buffer import config_pkg::*; #(
    parameter cfg_t        Cfg           = EmptyCfg,
    parameter int unsigned ROB_IDX_WIDTH = 6,
    parameter int unsigned SB_DEPTH      = 16,
    parameter int unsigned SB_IDX_WIDTH  = $clog2(SB_DEPTH)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     alloc_valid_i,
    output logic                     alloc_ready_o,
    output logic [SB_IDX_WIDTH-1:0]  alloc_sb_id_o,
    input  logic                     sb_ex_valid_i,
    input  logic [SB_IDX_WIDTH-1:0]  sb_ex_sb_id_i,
    input  logic [Cfg.PLEN-1:0]      sb_ex_addr_i,
    input  logic [Cfg.XLEN-1:0]      sb_ex_data_i,
    input  lsu_op_e                  sb_ex_op_i,
    input  logic [ROB_IDX_WIDTH-1:0] sb_ex_rob_idx_i,
    input  logic [ROB_IDX_WIDTH-1:0] rob_head_i,
    input  logic [Cfg.PLEN-1:0]      sb_load_addr_i,
    input  lsu_op_e                  sb_load_op_i,
    input  logic [ROB_IDX_WIDTH-1:0] sb_load_rob_idx_i,
    output logic                     sb_load_hit_o,
    output logic [Cfg.XLEN-1:0]      sb_load_data_o,
    input  logic                     commit_valid_i,
    output logic                     st_req_valid_o,
    input  logic                     st_req_ready_i,
    output logic [Cfg.PLEN-1:0]      st_req_addr_o,
    output logic [Cfg.XLEN-1:0]      st_req_data_o,
    output lsu_op_e                  st_req_op_o,
    output logic                     sb_empty_o
);
    localparam int unsigned XLEN = Cfg.XLEN;
    localparam int unsigned PLEN = Cfg.PLEN;
    localparam int unsigned PW   = SB_IDX_WIDTH + 1;
    typedef logic [SB_IDX_WIDTH-1:0] idx_t;
    typedef logic [PW-1:0]           ptr_t;

    ptr_t                     head, cmt, tail, cmt_n, count;
    logic [SB_DEPTH-1:0]      valid_q, filled_q, committed_q;
    logic [PLEN-1:0]          addr_q [SB_DEPTH];
    logic [XLEN-1:0]          data_q [SB_DEPTH];
    lsu_op_e                  op_q   [SB_DEPTH];
    logic [ROB_IDX_WIDTH-1:0] rob_q  [SB_DEPTH];
    idx_t                     head_idx, fwd_idx, fwd_sel;
    logic                     alloc_fire, drain_fire, commit_fire, fwd_found;
    logic [ROB_IDX_WIDTH-1:0] load_age;
    logic [3:0]               load_lo, load_hi;

    function automatic logic [3:0] size_of(lsu_op_e op);
        return 4'd1 << op;
    endfunction

    assign head_idx      = head[SB_IDX_WIDTH-1:0];
    assign count         = tail - head;
    assign alloc_ready_o = (count != PW'(SB_DEPTH)) && !flush_i;
    assign alloc_sb_id_o = tail[SB_IDX_WIDTH-1:0];
    assign alloc_fire    = alloc_valid_i && alloc_ready_o;
    assign commit_fire   = commit_valid_i && (cmt != tail);
    assign cmt_n         = cmt + PW'(commit_fire);
    assign sb_empty_o    = head == tail;

    assign st_req_valid_o = valid_q[head_idx] && committed_q[head_idx];
    assign st_req_addr_o  = addr_q[head_idx];
    assign st_req_data_o  = data_q[head_idx];
    assign st_req_op_o    = op_q[head_idx];
    assign drain_fire     = st_req_valid_o && st_req_ready_i;

    // Ages are measured as distance from the ROB head so wrapped tags order correctly.
    assign load_age = sb_load_rob_idx_i - rob_head_i;
    assign load_lo  = {1'b0, sb_load_addr_i[2:0]};
    assign load_hi  = load_lo + size_of(sb_load_op_i);

    // Walk from the youngest slot back; the first older overlapping store decides the outcome.
    always_comb begin
        fwd_found = 1'b0;
        fwd_sel   = '0;
        fwd_idx   = '0;
        for (int k = 0; k < int'(SB_DEPTH); k++) begin
            fwd_idx = tail[SB_IDX_WIDTH-1:0] - idx_t'(k + 1);
            if (!fwd_found && valid_q[fwd_idx] && filled_q[fwd_idx]
                && (committed_q[fwd_idx] || (rob_q[fwd_idx] - rob_head_i) < load_age)
                && addr_q[fwd_idx][PLEN-1:3] == sb_load_addr_i[PLEN-1:3]
                && {1'b0, addr_q[fwd_idx][2:0]} < load_hi
                && load_lo < {1'b0, addr_q[fwd_idx][2:0]} + size_of(op_q[fwd_idx])) begin
                fwd_found = 1'b1;
                fwd_sel   = fwd_idx;
            end
        end
    end

    assign sb_load_hit_o  = fwd_found && addr_q[fwd_sel] == sb_load_addr_i && op_q[fwd_sel] >= sb_load_op_i;
    assign sb_load_data_o = sb_load_hit_o ? data_q[fwd_sel] : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head        <= '0;
            cmt         <= '0;
            tail        <= '0;
            valid_q     <= '0;
            filled_q    <= '0;
            committed_q <= '0;
        end else begin
            if (sb_ex_valid_i && valid_q[sb_ex_sb_id_i]) begin
                addr_q[sb_ex_sb_id_i]   <= sb_ex_addr_i;
                data_q[sb_ex_sb_id_i]   <= sb_ex_data_i;
                op_q[sb_ex_sb_id_i]     <= sb_ex_op_i;
                rob_q[sb_ex_sb_id_i]    <= sb_ex_rob_idx_i;
                filled_q[sb_ex_sb_id_i] <= 1'b1;
            end
            if (drain_fire) begin
                valid_q[head_idx] <= 1'b0;
                head              <= head + 1'b1;
            end
            if (commit_fire) committed_q[cmt[SB_IDX_WIDTH-1:0]] <= 1'b1;
            cmt <= cmt_n;
            if (flush_i) begin
                // Slots in [cmt_n, tail) are uncommitted and are dropped; the drain slot is never among them.
                for (int i = 0; i < int'(SB_DEPTH); i++)
                    if (PW'(idx_t'(i) - cmt_n[SB_IDX_WIDTH-1:0]) < tail - cmt_n) valid_q[i] <= 1'b0;
                tail <= cmt_n;
            end else if (alloc_fire) begin
                valid_q[alloc_sb_id_o]     <= 1'b1;
                filled_q[alloc_sb_id_o]    <= 1'b0;
                committed_q[alloc_sb_id_o] <= 1'b0;
                tail                       <= tail + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i)
        if (!rst_i && commit_valid_i) assert (cmt != tail);
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed scoreboard bench for store_buffer
module tb_store_buffer;
    import config_pkg::*;

    logic          clk_i = 1'b0, rst_i = 1'b1, flush_i = 1'b0;
    logic          alloc_valid_i = 1'b0, alloc_ready_o;
    logic [3:0]    alloc_sb_id_o;
    logic          sb_ex_valid_i = 1'b0;
    logic [3:0]    sb_ex_sb_id_i = '0;
    logic [55:0]   sb_ex_addr_i = '0;
    logic [63:0]   sb_ex_data_i = '0;
    lsu_op_e       sb_ex_op_i = LSU_SB;
    logic [5:0]    sb_ex_rob_idx_i = '0, rob_head_i = '0;
    logic [55:0]   sb_load_addr_i = '0;
    lsu_op_e       sb_load_op_i = LSU_SB;
    logic [5:0]    sb_load_rob_idx_i = '0;
    logic          sb_load_hit_o;
    logic [63:0]   sb_load_data_o;
    logic          commit_valid_i = 1'b0;
    logic          st_req_valid_o, st_req_ready_i = 1'b0;
    logic [55:0]   st_req_addr_o;
    logic [63:0]   st_req_data_o;
    lsu_op_e       st_req_op_o;
    logic          sb_empty_o;

    int errors = 0, checks = 0;

    typedef struct {
        logic [55:0] a;
        logic [63:0] d;
        lsu_op_e     o;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk_i = ~clk_i;

    store_buffer dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o), .alloc_sb_id_o(alloc_sb_id_o),
        .sb_ex_valid_i(sb_ex_valid_i), .sb_ex_sb_id_i(sb_ex_sb_id_i), .sb_ex_addr_i(sb_ex_addr_i),
        .sb_ex_data_i(sb_ex_data_i), .sb_ex_op_i(sb_ex_op_i), .sb_ex_rob_idx_i(sb_ex_rob_idx_i),
        .rob_head_i(rob_head_i), .sb_load_addr_i(sb_load_addr_i), .sb_load_op_i(sb_load_op_i),
        .sb_load_rob_idx_i(sb_load_rob_idx_i), .sb_load_hit_o(sb_load_hit_o), .sb_load_data_o(sb_load_data_o),
        .commit_valid_i(commit_valid_i), .st_req_valid_o(st_req_valid_o), .st_req_ready_i(st_req_ready_i),
        .st_req_addr_o(st_req_addr_o), .st_req_data_o(st_req_data_o), .st_req_op_o(st_req_op_o),
        .sb_empty_o(sb_empty_o)
    );

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Every accepted store request is matched against the oldest expected store.
    always @(negedge clk_i) begin
        if (!rst_i && st_req_valid_o && st_req_ready_i) begin
            if (sb_q.size() == 0) chk("drain_unexpected", 64'(st_req_addr_o), 64'hFFFF_FFFF_FFFF_FFFF);
            else begin
                chk("drain_addr", 64'(st_req_addr_o), 64'(sb_q[0].a));
                chk("drain_data", st_req_data_o, sb_q[0].d);
                chk("drain_op", 64'(st_req_op_o), 64'(sb_q[0].o));
                void'(sb_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        flush_i = 1'b0;
        alloc_valid_i = 1'b0;
        sb_ex_valid_i = 1'b0;
        commit_valid_i = 1'b0;
        st_req_ready_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
        sb_q.delete();
    endtask

    task automatic alloc(string tag, logic [3:0] exp_id);
        alloc_valid_i = 1'b1;
        #1;
        chk({tag, "_ready"}, 64'(alloc_ready_o), 64'd1);
        chk({tag, "_id"}, 64'(alloc_sb_id_o), 64'(exp_id));
        tick();
        alloc_valid_i = 1'b0;
    endtask

    task automatic fill(logic [3:0] id, logic [55:0] a, logic [63:0] d, lsu_op_e o, logic [5:0] rob);
        sb_ex_valid_i = 1'b1;
        sb_ex_sb_id_i = id;
        sb_ex_addr_i = a;
        sb_ex_data_i = d;
        sb_ex_op_i = o;
        sb_ex_rob_idx_i = rob;
        tick();
        sb_ex_valid_i = 1'b0;
    endtask

    task automatic commit(logic [55:0] a, logic [63:0] d, lsu_op_e o);
        exp_t e;
        e.a = a;
        e.d = d;
        e.o = o;
        sb_q.push_back(e);
        commit_valid_i = 1'b1;
        tick();
        commit_valid_i = 1'b0;
    endtask

    task automatic query(string tag, logic [55:0] a, lsu_op_e o, logic [5:0] rob, logic hit, logic [63:0] d);
        sb_load_addr_i = a;
        sb_load_op_i = o;
        sb_load_rob_idx_i = rob;
        #1;
        chk({tag, "_hit"}, 64'(sb_load_hit_o), 64'(hit));
        chk({tag, "_data"}, sb_load_data_o, d);
    endtask

    task automatic wait_drained(string tag, int max);
        for (int n = 0; n < max && sb_q.size() != 0; n++) tick();
        tick();
        chk(tag, 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        do_reset();
        #1;
        chk("rst_ready", 64'(alloc_ready_o), 64'd1);
        chk("rst_id", 64'(alloc_sb_id_o), 64'd0);
        chk("rst_hit", 64'(sb_load_hit_o), 64'd0);
        chk("rst_data", sb_load_data_o, 64'd0);
        chk("rst_st_valid", 64'(st_req_valid_o), 64'd0);
        chk("rst_empty", 64'(sb_empty_o), 64'd1);

        for (int i = 0; i < 16; i++) alloc("fill_up", 4'(i));
        #1;
        chk("full_ready", 64'(alloc_ready_o), 64'd0);
        chk("full_empty", 64'(sb_empty_o), 64'd0);
        alloc_valid_i = 1'b1;
        tick();
        alloc_valid_i = 1'b0;
        #1;
        chk("full_17th_id", 64'(alloc_sb_id_o), 64'd0);
        chk("full_17th_ready", 64'(alloc_ready_o), 64'd0);

        do_reset();
        alloc("fwd", 4'd0);
        fill(4'd0, 56'h100, 64'hDEAD_BEEF, LSU_SW, 6'd3);
        query("fwd_younger_load", 56'h100, LSU_SW, 6'd5, 1'b1, 64'hDEAD_BEEF);
        query("fwd_older_load", 56'h100, LSU_SW, 6'd2, 1'b0, 64'd0);

        do_reset();
        alloc("yng", 4'd0);
        alloc("yng", 4'd1);
        fill(4'd0, 56'h101, 64'hAA, LSU_SB, 6'd1);
        fill(4'd1, 56'h100, 64'h1122_3344, LSU_SW, 6'd2);
        query("fwd_youngest", 56'h100, LSU_SW, 6'd5, 1'b1, 64'h1122_3344);

        do_reset();
        alloc("part", 4'd0);
        alloc("part", 4'd1);
        fill(4'd0, 56'h101, 64'hAA, LSU_SB, 6'd1);
        fill(4'd1, 56'h102, 64'hBB, LSU_SB, 6'd2);
        query("fwd_partial", 56'h100, LSU_SW, 6'd5, 1'b0, 64'd0);
        query("fwd_byte", 56'h101, LSU_SB, 6'd5, 1'b1, 64'hAA);

        commit(56'h101, 64'hAA, LSU_SB);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_valid", 64'(st_req_valid_o), 64'd1);
            chk("stall_addr", 64'(st_req_addr_o), 64'h101);
            chk("stall_data", st_req_data_o, 64'hAA);
            tick();
        end
        st_req_ready_i = 1'b1;
        tick();
        chk("after_drain_valid", 64'(st_req_valid_o), 64'd0);
        chk("after_drain_empty", 64'(sb_empty_o), 64'd0);
        commit(56'h102, 64'hBB, LSU_SB);
        tick();
        chk("drained_empty", 64'(sb_empty_o), 64'd1);
        chk("drained_q", 64'(sb_q.size()), 64'd0);

        do_reset();
        for (int i = 0; i < 4; i++) alloc("fl", 4'(i));
        for (int i = 0; i < 4; i++) fill(4'(i), 56'h200 + 56'(8 * i), 64'h1000 + 64'(i), LSU_SD, 6'(i));
        commit(56'h200, 64'h1000, LSU_SD);
        commit(56'h208, 64'h1001, LSU_SD);
        flush_i = 1'b1;
        #1;
        chk("flush_blocks_alloc", 64'(alloc_ready_o), 64'd0);
        tick();
        flush_i = 1'b0;
        query("flushed_entry", 56'h210, LSU_SD, 6'd10, 1'b0, 64'd0);
        query("kept_entry", 56'h200, LSU_SD, 6'd10, 1'b1, 64'h1000);
        st_req_ready_i = 1'b1;
        alloc("after_flush", 4'd2);
        wait_drained("flush_drain_q", 20);
        chk("flush_no_more", 64'(st_req_valid_o), 64'd0);
        chk("flush_not_empty", 64'(sb_empty_o), 64'd0);

        do_reset();
        st_req_ready_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            logic [63:0] d;
            d = {$urandom, $urandom};
            alloc("wrap", 4'(i % 16));
            fill(4'(i % 16), 56'h1000 + 56'(8 * i), d, LSU_SD, 6'(i));
            commit(56'h1000 + 56'(8 * i), d, LSU_SD);
        end
        wait_drained("wrap_drain_q", 20);
        chk("wrap_empty", 64'(sb_empty_o), 64'd1);

        do_reset();
        alloc("mid", 4'd0);
        fill(4'd0, 56'h300, 64'h55, LSU_SW, 6'd0);
        commit(56'h300, 64'h55, LSU_SW);
        #1;
        chk("mid_valid", 64'(st_req_valid_o), 64'd1);
        sb_q.delete();
        rst_i = 1'b1;
        tick();
        chk("mid_rst_valid", 64'(st_req_valid_o), 64'd0);
        chk("mid_rst_empty", 64'(sb_empty_o), 64'd1);
        rst_i = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
